// File: rtl/sc_fft4_ctrl_if.sv
// Stream handshake plus datapath control bundle for the 4-point FFT sequencer.
interface sc_fft4_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic s0;
  logic s1;
  logic s2;
  logic s3;
  logic tw_neg;
  logic out_valid;
  logic out_last;

  // Upstream source / datapath side.
  modport master (
    output in_valid,
    input  in_ready, s0, s1, s2, s3, tw_neg, out_valid, out_last
  );

  // Sequencer side.
  modport slave (
    input  in_valid,
    output in_ready, s0, s1, s2, s3, tw_neg, out_valid, out_last
  );
endinterface

// File: rtl/sc_fft4_ctrl.sv
// Sequencer for the 2-parallel serial-commutator 4-point FFT datapath.
// Tracks frame position, tags each accepted pair through phase/valid pipes,
// detects broken frames, drains in-flight pairs and counts completed frames.
module sc_fft4_ctrl #(
  parameter int LAT    = 6,
  parameter int S0_DLY = 0,
  parameter int S1_DLY = 1,
  parameter int TW_DLY = 2,
  parameter int S2_DLY = 3,
  parameter int S3_DLY = 5,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  sc_fft4_ctrl_if.slave    bus,
  input  logic             clr_err,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int DW = $clog2(LAT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, ERR} state_t;

  state_t          state, next_state;
  logic            ready;
  logic            accept;
  logic            flush;
  logic            half;
  logic [DW-1:0]   drain_cnt;
  logic [LAT-1:0]  v_sr, ph_sr;
  // Index 0 is the current (combinational) pair, index k is the pair k cycles ago.
  logic [LAT:0]    v_all, ph_all;

  assign accept = bus.in_valid & ready;
  assign flush  = (state == ERR) || (next_state == ERR);
  assign v_all  = {v_sr, accept};
  assign ph_all = {ph_sr, accept & half};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; in RUN a gap is legal only after the second pair of a frame.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (accept) next_state = RUN;
      RUN:   if (!bus.in_valid) next_state = half ? ERR : DRAIN;
      DRAIN: begin
        if (accept)                         next_state = RUN;
        else if (drain_cnt == DW'(LAT - 1)) next_state = IDLE;
      end
      ERR:   if (clr_err) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ready = (state != ERR);
    err   = (state == ERR);
  end

  // Frame position, drain timer and the phase/valid pipes; ERR flushes everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      half  <= 1'b0;
      v_sr  <= '0;
      ph_sr <= '0;
    end else begin
      if (accept) half <= ~half;
      v_sr  <= v_all[LAT-1:0];
      ph_sr <= ph_all[LAT-1:0];
    end
  end

  // Counts idle cycles spent in DRAIN.
  always_ff @(posedge clk) begin
    if (!rst_n || state != DRAIN || accept) drain_cnt <= '0;
    else                                    drain_cnt <= drain_cnt + DW'(1);
  end

  // Completed-frame counter, wraps freely.
  always_ff @(posedge clk) begin
    if (!rst_n)                           frame_cnt <= '0;
    else if (bus.out_valid && bus.out_last) frame_cnt <= frame_cnt + CNT_W'(1);
  end

  // Control taps to the datapath.
  always_comb begin
    bus.in_ready  = ready;
    bus.s0        = ph_all[S0_DLY];
    bus.s1        = ph_all[S1_DLY];
    bus.tw_neg    = ph_all[TW_DLY];
    bus.s2        = ph_all[S2_DLY];
    bus.s3        = ph_all[S3_DLY];
    bus.out_valid = v_all[LAT];
    bus.out_last  = v_all[LAT] & ph_all[LAT];
    busy          = |v_sr;
  end

endmodule
